// File: rtl/spi_mem_sequencer.sv
// spi_mem_sequencer: expands single-byte EEPROM read/write requests into SPI byte frames for M_SpiSender
module spi_mem_sequencer #(
  parameter int POLL_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        eng_start,
  output logic        eng_continued,
  output logic [7:0]  eng_txData,
  input  logic [7:0]  eng_rxData,
  input  logic        eng_ready
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, NEXT, POLL, RESP} state_t;
  typedef enum logic [1:0] {F_READ, F_WREN, F_WRITE, F_RDSR} frame_t;
  localparam logic [15:0] PMAX = 16'(POLL_MAX);
  state_t state_q, state_d;
  frame_t frame_q, frame_d;
  logic [1:0] idx_q, idx_d;
  logic [15:0] addr_q, addr_d, poll_q, poll_d;
  logic [7:0] wdata_q, wdata_d, rx_q, rx_d, rdata_q, rdata_d, tx_q, tx_d, cmd_b, tx_b;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic busy_q, busy_d, start_q, start_d, cont_q, cont_d, load;
  function automatic logic [1:0] last_of(input frame_t f);
    return f == F_WREN ? 2'd0 : f == F_RDSR ? 2'd1 : 2'd3;
  endfunction
  // frame/byte sequencing and response decisions
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d = idx_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    poll_d = poll_q;
    rx_d = rx_q;
    rdata_d = rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        state_d = SEND;
        frame_d = cmd_write ? F_WREN : F_READ;
        idx_d = 2'd0;
        addr_d = cmd_addr;
        wdata_d = cmd_wdata;
        poll_d = 16'd0;
      end
      SEND: state_d = eng_ready ? SEND : WAIT_DONE;
      WAIT_DONE: if (eng_ready) begin
        rx_d = eng_rxData;
        state_d = NEXT;
      end
      NEXT: if (idx_q != last_of(frame_q)) begin
        idx_d = idx_q + 2'd1;
        state_d = SEND;
      end else begin
        idx_d = 2'd0;
        case (frame_q)
          F_READ: begin
            state_d = RESP;
            rdata_d = rx_q;
            rsp_err_d = 1'b0;
          end
          F_WREN: begin
            frame_d = F_WRITE;
            state_d = SEND;
          end
          F_WRITE: begin
            frame_d = F_RDSR;
            state_d = SEND;
          end
          default: begin
            poll_d = poll_q + 16'd1;
            state_d = POLL;
          end
        endcase
      end
      POLL: begin
        state_d = (rx_q[0] && poll_q < PMAX) ? SEND : RESP;
        rdata_d = 8'h00;
        rsp_err_d = rx_q[0] && poll_q >= PMAX;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // registered outputs derived from the next state; tx byte latched only on SEND entry
  always_comb begin
    cmd_b = frame_d == F_READ ? 8'h03 : frame_d == F_WREN ? 8'h06 : frame_d == F_WRITE ? 8'h02 : 8'h05;
    tx_b = idx_d == 2'd0 ? cmd_b : frame_d == F_RDSR ? 8'hFF : idx_d == 2'd1 ? addr_d[15:8] :
           idx_d == 2'd2 ? addr_d[7:0] : frame_d == F_READ ? 8'hFF : wdata_d;
    load = state_d == SEND && state_q != SEND;
    tx_d = load ? tx_b : tx_q;
    cont_d = load ? idx_d != last_of(frame_d) : cont_q;
    start_d = state_d == SEND;
    busy_d = state_d != IDLE;
    rsp_valid_d = state_d == RESP;
    cmd_ready_d = state_d == IDLE && eng_ready;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= F_READ;
      idx_q <= 2'd0;
      addr_q <= 16'd0;
      wdata_q <= 8'd0;
      poll_q <= 16'd0;
      rx_q <= 8'd0;
      rdata_q <= 8'd0;
      rsp_err_q <= 1'b0;
      tx_q <= 8'hFF;
      cont_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      poll_q <= poll_d;
      rx_q <= rx_d;
      rdata_q <= rdata_d;
      rsp_err_q <= rsp_err_d;
      tx_q <= tx_d;
      cont_q <= cont_d;
      start_q <= start_d;
      busy_q <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err = rsp_err_q;
  assign busy = busy_q;
  assign eng_start = start_q;
  assign eng_continued = cont_q;
  assign eng_txData = tx_q;
endmodule

// File: tb/tb_spi_mem_sequencer.sv
// tb_spi_mem_sequencer: directed checks of the sequencer against a byte-engine/EEPROM model
module tb_spi_mem_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic cmd_ready, rsp_valid, rsp_err, busy, eng_start, eng_continued;
  logic [7:0] rsp_rdata, eng_txData;
  logic [7:0] eng_rxData = 8'd0;
  logic eng_ready = 1'b1;
  int total = 0, bad = 0;
  int cyc = 0, acc_cnt = 0, rsp_cnt = 0, rsp_cyc = 0, acc_gap = 0;
  logic [7:0] got_rdata;
  logic got_err;
  logic [8:0] log_q[$];
  int wip_left = 0, rdsr_frames = 0;
  bit wip_stuck = 1'b0;
  logic [8:0] exp_rd[4] = '{9'h103, 9'h112, 9'h134, 9'h0FF};
  logic [8:0] exp_wr[7] = '{9'h006, 9'h102, 9'h100, 9'h110, 9'h05C, 9'h105, 9'h0FF};

  spi_mem_sequencer #(.POLL_MAX(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .eng_start(eng_start), .eng_continued(eng_continued),
    .eng_txData(eng_txData), .eng_rxData(eng_rxData), .eng_ready(eng_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      acc_gap = cyc - rsp_cyc;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      got_rdata = rsp_rdata;
      got_err = rsp_err;
    end
  end

  initial begin
    logic [7:0] fb[8];
    logic [7:0] rx;
    int pos, left;
    pos = 0;
    left = 0;
    rx = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        eng_ready = 1'b1;
        pos = 0;
        left = 0;
      end else if (eng_ready && eng_start) begin
        log_q.push_back({eng_continued, eng_txData});
        fb[pos] = eng_txData;
        rx = 8'h00;
        if (fb[0] == 8'h03 && pos == 3) rx = (fb[1] == 8'h12 && fb[2] == 8'h34) ? 8'hA5 : 8'h3C;
        if (fb[0] == 8'h05 && pos == 1) begin
          rx = {7'd0, wip_stuck || wip_left > 0};
          if (wip_left > 0) wip_left--;
          rdsr_frames++;
        end
        pos = (eng_continued && pos < 7) ? pos + 1 : 0;
        eng_ready = 1'b0;
        left = 3;
      end else if (!eng_ready) begin
        left--;
        if (left == 0) begin
          eng_ready = 1'b1;
          eng_rxData = rx;
        end
      end
    end
  end

  task automatic req(input logic w, input logic [15:0] a, input logic [7:0] d);
    int n, base;
    n = 0;
    base = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = 16'hFFFF;
    cmd_wdata = 8'h00;
    chk("acc_busy", busy, 1);
    chk("acc_start", eng_start, 1);
    chk("acc_ready", cmd_ready, 0);
    n = 0;
    while (rsp_cnt == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("rsp_count", rsp_cnt, base + 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rdata"}, rsp_rdata, 8'h00);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, eng_start, 0);
    chk({tag, "_cont"}, eng_continued, 0);
    chk({tag, "_tx"}, eng_txData, 8'hFF);
  endtask

  initial begin
    int n, base_acc, base_rsp;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    log_q.delete();
    req(1'b0, 16'h1234, 8'h00);
    chk("rd_len", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rd_b%0d", i), log_q[i], exp_rd[i]);
    chk("rd_data", got_rdata, 8'hA5);
    chk("rd_err", got_err, 0);

    log_q.delete();
    rdsr_frames = 0;
    wip_left = 0;
    req(1'b1, 16'h0010, 8'h5C);
    chk("wr_len", log_q.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("wr_b%0d", i), log_q[i], exp_wr[i]);
    chk("wr_rdsr", rdsr_frames, 1);
    chk("wr_data", got_rdata, 8'h00);
    chk("wr_err", got_err, 0);

    log_q.delete();
    rdsr_frames = 0;
    wip_left = 3;
    req(1'b1, 16'h0011, 8'h33);
    chk("wip_rdsr", rdsr_frames, 4);
    chk("wip_len", log_q.size(), 13);
    chk("wip_err", got_err, 0);

    rdsr_frames = 0;
    wip_stuck = 1'b1;
    req(1'b1, 16'h0012, 8'h44);
    wip_stuck = 1'b0;
    chk("to_rdsr", rdsr_frames, 4);
    chk("to_err", got_err, 1);
    chk("to_idle_ready", cmd_ready, 1);

    base_acc = acc_cnt;
    base_rsp = rsp_cnt;
    wip_left = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 16'h0020;
    cmd_wdata = 8'h77;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_write = 1'b0;
    cmd_addr = 16'h1234;
    n = 0;
    while (acc_cnt < base_acc + 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_cnt < base_rsp + 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("hold_acc", acc_cnt, base_acc + 2);
    chk("hold_gap", acc_gap, 1);
    chk("hold_rsp", rsp_cnt, base_rsp + 2);
    chk("hold_data", got_rdata, 8'hA5);

    log_q.delete();
    base_rsp = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 16'h1234;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (log_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready", cmd_ready, 1);
    repeat (20) @(negedge clk);
    chk("mid_no_rsp", rsp_cnt, base_rsp);

    log_q.delete();
    req(1'b0, 16'h1234, 8'h00);
    chk("post_len", log_q.size(), 4);
    chk("post_data", got_rdata, 8'hA5);
    chk("post_err", got_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
